// File: rtl/float_to_int_if.sv
// Handshake bundle between the adder result producer, the float_to_int converter
// and its integer consumer. The converter sits on the slave side.
interface float_to_int_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );
endinterface

// File: rtl/float_to_int.sv
// binary32 -> signed int32 converter, truncating toward zero.
// Iterative one-bit-per-cycle shifter; one operand in flight at a time.
module float_to_int (
  input  logic           clk,
  input  logic           rst,
  float_to_int_if.slave  bus
);

  typedef enum logic [2:0] {
    GET_A,
    UNPACK,
    SPECIAL,
    CONVERT,
    PUT_Z
  } state_t;

  localparam logic signed [9:0] E_ZERO_DENORM = -10'sd127;
  localparam logic signed [9:0] E_MAX_FIT     = 10'sd30;
  localparam logic signed [9:0] E_DONE        = 10'sd31;
  localparam logic [31:0]       Z_OVERFLOW    = 32'h8000_0000;

  state_t             state_reg, state_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        m_reg, m_next;
  logic [31:0]        z_reg, z_next;
  logic signed [9:0]  e_reg, e_next;
  logic               s_reg, s_next;
  logic               ack_reg, ack_next;
  logic               stb_reg, stb_next;

  // Control and result registers carry a reset; the datapath scratch does not.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= GET_A;
      ack_reg   <= 1'b0;
      stb_reg   <= 1'b0;
      z_reg     <= 32'd0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      stb_reg   <= stb_next;
      z_reg     <= z_next;
    end
  end

  always_ff @(posedge clk) begin
    a_reg <= a_next;
    m_reg <= m_next;
    e_reg <= e_next;
    s_reg <= s_next;
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    m_next     = m_reg;
    e_next     = e_reg;
    s_next     = s_reg;
    z_next     = z_reg;
    ack_next   = ack_reg;
    stb_next   = stb_reg;

    case (state_reg)
      GET_A: begin
        if (!ack_reg) begin
          ack_next = 1'b1;
        end else if (bus.input_a_stb) begin
          a_next     = bus.input_a;
          ack_next   = 1'b0;
          state_next = UNPACK;
        end
      end

      UNPACK: begin
        m_next     = {1'b1, a_reg[22:0], 8'b0};
        e_next     = $signed({2'b00, a_reg[30:23]} - 10'd127);
        s_next     = a_reg[31];
        state_next = SPECIAL;
      end

      // Zero/denormal must win over the small-magnitude test: both give 0,
      // but the order keeps the decision tree identical to the producer's.
      SPECIAL: begin
        if (e_reg == E_ZERO_DENORM) begin
          z_next     = 32'd0;
          stb_next   = 1'b1;
          state_next = PUT_Z;
        end else if (e_reg > E_MAX_FIT) begin
          z_next     = Z_OVERFLOW;
          stb_next   = 1'b1;
          state_next = PUT_Z;
        end else if (e_reg < 10'sd0) begin
          z_next     = 32'd0;
          stb_next   = 1'b1;
          state_next = PUT_Z;
        end else begin
          state_next = CONVERT;
        end
      end

      // The leading one starts at bit 31; each shift moves the binary point
      // one place until the integer part is right-aligned.
      CONVERT: begin
        if (e_reg < E_DONE) begin
          m_next = m_reg >> 1;
          e_next = e_reg + 10'sd1;
        end else begin
          z_next     = s_reg ? (~m_reg + 32'd1) : m_reg;
          stb_next   = 1'b1;
          state_next = PUT_Z;
        end
      end

      PUT_Z: begin
        if (bus.output_z_ack) begin
          stb_next   = 1'b0;
          ack_next   = 1'b1;
          state_next = GET_A;
        end
      end

      default: begin
        state_next = GET_A;
      end
    endcase
  end

  assign bus.input_a_ack  = ack_reg;
  assign bus.output_z_stb = stb_reg;
  assign bus.output_z     = z_reg;

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: expected integer and latency are pushed
// when an operand is driven and popped when the converter presents a result.
module tb_float_to_int;

  typedef struct {
    logic [31:0] val;
    int          lat;
    logic [31:0] operand;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   accept_cnt;
  exp_t sb[$];

  float_to_int_if bus ();

  float_to_int dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.input_a_stb && bus.input_a_ack)
      accept_cnt <= accept_cnt + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: decode the float arithmetically and shift the significand directly.
  function automatic exp_t model(input logic [31:0] f);
    exp_t        r;
    int          ex;
    int          ub;
    logic [63:0] mag;
    ex = int'(f[30:23]);
    ub = ex - 127;
    r.operand = f;
    r.lat = 2;
    r.val = 32'd0;
    if (ex == 0) begin
      r.val = 32'd0;
    end else if (ub > 30) begin
      r.val = 32'h8000_0000;
    end else if (ub < 0) begin
      r.val = 32'd0;
    end else begin
      mag = {40'd0, 1'b1, f[22:0]};
      if (ub >= 23) mag = mag << (ub - 23);
      else          mag = mag >> (23 - ub);
      r.val = f[31] ? (32'd0 - mag[31:0]) : mag[31:0];
      r.lat = 34 - ub;
    end
    return r;
  endfunction

  // Drives one operand, returns the observed result and edges from acceptance.
  task automatic run_op(input logic [31:0] f, output logic [31:0] z,
                        output int lat, output bit to);
    int g;
    to  = 1'b0;
    lat = 0;
    z   = 32'hxxxx_xxxx;
    @(negedge clk);
    bus.input_a     = f;
    bus.input_a_stb = 1'b1;
    g = 0;
    while (!bus.input_a_ack && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (!bus.input_a_ack) begin
      to = 1'b1;
      bus.input_a_stb = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      #1;
    end while (!bus.output_z_stb && lat < 80);
    if (!bus.output_z_stb) to = 1'b1;
    z = bus.output_z;
    $display("op %h -> %h after %0d edges", f, z, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.input_a      = 32'd0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.input_a_ack !== 1'b0 || bus.output_z_stb !== 1'b0 || bus.output_z !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state: ack=%b stb=%b z=%h, required ack=0 stb=0 z=00000000",
               bus.input_a_ack, bus.output_z_stb, bus.output_z);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.input_a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ack_rise: ack=%b, required 1", bus.input_a_ack);
    end
  endtask

  task automatic test_values(input string name, input logic [31:0] ops[]);
    logic [31:0] z;
    int          lat;
    bit          to;
    exp_t        e;
    foreach (ops[i]) begin
      sb.push_back(model(ops[i]));
      run_op(ops[i], z, lat, to);
      e = sb.pop_front();
      n_checks++;
      if (to) begin
        n_fail++;
        $display("FAIL %s_timeout: operand %h produced no result", name, e.operand);
        continue;
      end
      n_checks++;
      if (z !== e.val) begin
        n_fail++;
        $display("FAIL %s_value: operand %h got %h, required %h", name, e.operand, z, e.val);
      end
      n_checks++;
      if (lat != e.lat) begin
        n_fail++;
        $display("FAIL %s_latency: operand %h got %0d edges, required %0d",
                 name, e.operand, lat, e.lat);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_one_cycle: stb=%b ack=%b after handshake, required stb=0 ack=1",
                 name, bus.output_z_stb, bus.input_a_ack);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] z;
    int          lat;
    bit          to;
    int          base;
    exp_t        e;
    bus.output_z_ack = 1'b0;
    sb.push_back(model(32'h41B8_0000));
    run_op(32'h41B8_0000, z, lat, to);
    e = sb.pop_front();
    base = accept_cnt;
    n_checks++;
    if (to || z !== e.val) begin
      n_fail++;
      $display("FAIL bp_value: got %h (timeout=%b), required %h", z, to, e.val);
    end
    for (int i = 0; i < 10; i++) begin
      bus.input_a     = $urandom;
      bus.input_a_stb = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.output_z_stb !== 1'b1 || bus.output_z !== e.val || bus.input_a_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: stb=%b z=%h ack=%b, required stb=1 z=%h ack=0",
                 i, bus.output_z_stb, bus.output_z, bus.input_a_ack, e.val);
      end
    end
    @(negedge clk);
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: stb=%b ack=%b, required stb=0 ack=1",
               bus.output_z_stb, bus.input_a_ack);
    end
    n_checks++;
    if (accept_cnt != base) begin
      n_fail++;
      $display("FAIL bp_ignored_input: accepts=%0d, required %0d", accept_cnt, base);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] z;
    int          lat;
    bit          to;
    int          g;
    exp_t        e;
    @(negedge clk);
    bus.input_a     = 32'h3F80_0000;
    bus.input_a_stb = 1'b1;
    g = 0;
    while (!bus.input_a_ack && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (bus.output_z_stb !== 1'b0 || bus.input_a_ack !== 1'b0 || bus.output_z !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_reset: stb=%b ack=%b z=%h, required stb=0 ack=0 z=00000000",
               bus.output_z_stb, bus.input_a_ack, bus.output_z);
    end
    sb.push_back(model(32'h417C_0000));
    run_op(32'h417C_0000, z, lat, to);
    e = sb.pop_front();
    n_checks++;
    if (to || z !== e.val || lat != e.lat) begin
      n_fail++;
      $display("FAIL mid_reset_recover: got %h lat %0d (timeout=%b), required %h lat %0d",
               z, lat, to, e.val, e.lat);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int   base;
    int   g;
    exp_t e;
    base = accept_cnt;
    sb.push_back(model(32'h4040_0000));
    sb.push_back(model(32'h4E80_0000));
    @(negedge clk);
    bus.input_a     = 32'h4040_0000;
    bus.input_a_stb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      g = 0;
      while (accept_cnt != base + k + 1 && g < 80) begin
        @(posedge clk);
        #1;
        g++;
      end
      if (k == 0) bus.input_a = 32'h4E80_0000;
      else        bus.input_a_stb = 1'b0;
      g = 0;
      while (!bus.output_z_stb && g < 80) begin
        @(posedge clk);
        #1;
        g++;
      end
      e = sb.pop_front();
      $display("op %h -> %h (back-to-back)", e.operand, bus.output_z);
      n_checks++;
      if (!bus.output_z_stb || bus.output_z !== e.val) begin
        n_fail++;
        $display("FAIL b2b_value%0d: operand %h got %h (stb=%b), required %h",
                 k, e.operand, bus.output_z, bus.output_z_stb, e.val);
      end
    end
    bus.input_a_stb = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (accept_cnt != base + 2) begin
      n_fail++;
      $display("FAIL b2b_accept_count: got %0d accepts, required 2", accept_cnt - base);
    end
  endtask

  initial begin
    logic [31:0] normal_ops[];
    logic [31:0] special_ops[];
    n_checks   = 0;
    n_fail     = 0;
    accept_cnt = 0;
    normal_ops  = '{32'h41B8_0000, 32'hC1B8_0000, 32'h3F80_0000, 32'h417C_0000,
                    32'h4E80_0000, 32'hC2F6_E979};
    special_ops = '{32'h3F40_0000, 32'h8000_0000, 32'h0000_0001, 32'h7F80_0000,
                    32'h7FC0_0000, 32'h4F00_0000, 32'hCF00_0000};
    test_reset();
    test_values("normal", normal_ops);
    test_values("special", special_ops);
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
